// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the mem_arb block
// Purpose: FSM state encoding, requester owner encoding and counter width
// used by mem_arb and mem_arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - picks which requester wins the shared memory port
// Purpose: combinational arbitration decision between fetch and data.
// Config macro: MEM_ARB_RR_EN selects alternating priority on a tie;
// otherwise data always wins a tie.
// Ports:
//   if_req     in  fetch request
//   d_req      in  data request
//   last_owner in  most recent owner (OWN_IF / OWN_D)
//   winner     out selected owner; only meaningful when a request is high
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_owner,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_D;
    if (if_req && d_req) begin
      // Tie goes to whoever did not own the port last time.
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = (if_req && !d_req) ? OWN_IF : OWN_D;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester arbiter for a single fixed-latency memory port
// Purpose: serialises fetch and data accesses onto one memory port using an
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP FSM with registered outputs.
// Config macro: MEM_ARB_RR_EN enables alternating tie-break with a last-owner
// pointer; default build is fixed data priority.
// Ports:
//   clk, rst_n                      clock, synchronous active-high reset
//   if_req/if_addr                  fetch request
//   if_gnt/if_rvalid/if_rdata       fetch grant, response strobe, read data
//   d_req/d_we/d_addr/d_wdata       data load/store request
//   d_gnt/d_done/d_rdata            data grant, completion strobe, load data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata             shared memory port
//   busy                            FSM not in IDLE
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
  logic              last_owner;
  logic              winner;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign last_owner = last_q;
`else
  assign last_owner = OWN_D;
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_done_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = ACCESS;
          cnt_d    = CNT_INIT;
          owner_d  = winner;
          mem_en_d = 1'b1;
`ifdef MEM_ARB_RR_EN
          last_d   = winner;
`endif
          if (winner == OWN_D) begin
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            mem_we_d = d_we;
            d_gnt_d  = 1'b1;
          end else begin
            addr_d   = if_addr;
            mem_we_d = 1'b0;
            if_gnt_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // mem_we_q still holds the access type here; stores keep rdata.
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          state_d  = RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
          end else begin
            if_rvalid_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      // Pretending fetch owned last makes data win the first tie.
      last_q      <= OWN_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_done    = d_done_q;
  assign d_rdata   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb (MEM_LAT=2 and MEM_LAT=1)
module tb_mem_arb;

  localparam logic [6:0] IG = 7'b1000000;
  localparam logic [6:0] IV = 7'b0100000;
  localparam logic [6:0] DG = 7'b0010000;
  localparam logic [6:0] DD = 7'b0001000;
  localparam logic [6:0] EN = 7'b0000100;
  localparam logic [6:0] WE = 7'b0000010;
  localparam logic [6:0] BZ = 7'b0000001;

  typedef struct packed {
    logic        ir;
    logic [63:0] ia;
    logic        dr;
    logic        dw;
    logic [63:0] da;
    logic [63:0] dd;
    logic [6:0]  ctl;
    logic [63:0] ea;
    logic [63:0] ew;
    logic [63:0] er;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic if_req, d_req, d_we;
  logic [63:0] if_addr, d_addr, d_wdata;

  logic if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we, busy;
  logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_gnt1, if_rvalid1, d_gnt1, d_done1, mem_en1, mem_we1, busy1;
  logic [63:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    case (a)
      64'h100: return 64'h00500093;
      64'h8:   return 64'h42;
      default: return {a[31:0] ^ 32'h5A5A0000, a[31:0]};
    endcase
  endfunction

  assign mem_rdata  = mem_model(mem_addr);
  assign mem_rdata1 = mem_model(mem_addr1);

  mem_arb #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arb #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
  );

  function automatic vec_t mk(input logic ir, input logic [63:0] ia,
                              input logic dr, input logic dw,
                              input logic [63:0] da, input logic [63:0] dd,
                              input logic [6:0] ctl, input logic [63:0] ea,
                              input logic [63:0] ew, input logic [63:0] er);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.ctl = ctl; v.ea = ea; v.ew = ew; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl0();
    return {if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we, busy};
  endfunction

  function automatic logic [6:0] ctl1();
    return {if_gnt1, if_rvalid1, d_gnt1, d_done1, mem_en1, mem_we1, busy1};
  endfunction

  task automatic drive(input logic ir, input logic [63:0] ia, input logic dr,
                       input logic dw, input logic [63:0] da, input logic [63:0] dd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  initial begin
    logic [6:0] ctl_tie;
    logic [63:0] a_tie;
    logic own_d;

    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset ctl", {57'd0, ctl0()}, 64'd0);
    check("reset rdata", if_rdata, 64'd0);
    check("reset addr", mem_addr, 64'd0);
    check("reset ctl lat1", {57'd0, ctl1()}, 64'd0);
    rst_n = 1'b0;

    // fetch read
    vecs.push_back(mk(1, 64'h100, 0, 0, 0, 0, 7'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, IG | EN | BZ, 64'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, EN | BZ, 64'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, IV | BZ, 0, 0, 64'h00500093));
    // store; rdata must keep the fetch value
    vecs.push_back(mk(0, 0, 1, 1, 64'h2000, 64'hDEADBEEF, 7'd0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, DG | EN | WE | BZ, 64'h2000, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, EN | WE | BZ, 64'h2000, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, DD | BZ, 0, 0, 64'h00500093));
    // load, with a fetch request raised mid-access that must be ignored
    vecs.push_back(mk(0, 0, 1, 0, 64'h8, 0, 7'd0, 0, 0, 0));
    vecs.push_back(mk(1, 64'h200, 0, 0, 0, 0, DG | EN | BZ, 64'h8, 0, 0));
    vecs.push_back(mk(1, 64'h200, 0, 0, 0, 0, EN | BZ, 64'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, DD | BZ, 0, 0, 64'h42));
    // three accesses with both requests held high
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
      own_d = (k != 1);
`else
      own_d = 1'b1;
`endif
      a_tie   = own_d ? 64'h30 : 64'h40;
      ctl_tie = own_d ? DG : IG;
      vecs.push_back(mk(1, 64'h40, 1, 0, 64'h30, 0, 7'd0, 0, 0, 0));
      vecs.push_back(mk(1, 64'h40, 1, 0, 64'h30, 0, ctl_tie | EN | BZ, a_tie, 0, 0));
      vecs.push_back(mk(1, 64'h40, 1, 0, 64'h30, 0, EN | BZ, a_tie, 0, 0));
      vecs.push_back(mk(1, 64'h40, 1, 0, 64'h30, 0, (own_d ? DD : IV) | BZ, 0, 0, mem_model(a_tie)));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      check($sformatf("row%0d ctl", i), {57'd0, ctl0()}, {57'd0, vecs[i].ctl});
      if ((vecs[i].ctl & EN) != 0) check($sformatf("row%0d addr", i), mem_addr, vecs[i].ea);
      if ((vecs[i].ctl & WE) != 0) check($sformatf("row%0d wdata", i), mem_wdata, vecs[i].ew);
      if ((vecs[i].ctl & IV) != 0) check($sformatf("row%0d if_rdata", i), if_rdata, vecs[i].er);
      if ((vecs[i].ctl & DD) != 0) check($sformatf("row%0d d_rdata", i), d_rdata, vecs[i].er);
    end

    // let dut1 settle, then a request pulse that falls before any edge
    repeat (4) @(negedge clk);
    drive(1, 64'h300, 0, 0, 0, 0);
    #2 drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("withdrawn req ctl", {57'd0, ctl0()}, 64'd0);

    // reset in second ACCESS cycle
    drive(0, 0, 1, 1, 64'h50, 64'h1234);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("midrst gnt", {57'd0, ctl0()}, {57'd0, DG | EN | WE | BZ});
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst access2", {57'd0, ctl0()}, {57'd0, EN | WE | BZ});
    @(negedge clk);
    rst_n = 1'b0;
    check("midrst after", {57'd0, ctl0()}, 64'd0);
    check("midrst addr", mem_addr, 64'd0);
    @(negedge clk);
    check("midrst no done", {57'd0, ctl0()}, 64'd0);

    // MEM_LAT=1 load
    drive(0, 0, 1, 0, 64'h8, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("lat1 gnt", {57'd0, ctl1()}, {57'd0, DG | EN | BZ});
    check("lat1 addr", mem_addr1, 64'h8);
    @(negedge clk);
    check("lat1 done", {57'd0, ctl1()}, {57'd0, DD | BZ});
    check("lat1 rdata", d_rdata1, 64'h42);
    @(negedge clk);
    check("lat1 idle", {57'd0, ctl1()}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, address width.
REQ-002 SHALL have parameter: DATA_W, 64, data width.
REQ-003 SHALL have parameter: MEM_LAT, 2, memory access cycles (legal range 1..15).
REQ-004 SHALL have port: clk  in  1  clock, rising edge, the only clock.
REQ-005 SHALL have port: rst_n  in  1  reset, synchronous, active-high despite the name.
REQ-006 SHALL have ports: if_req in 1, if_addr in ADDR_W; the instruction-fetch request and its address.
REQ-007 SHALL have ports: if_gnt out 1, if_rvalid out 1, if_rdata out DATA_W; the fetch grant, response strobe and read data.
REQ-008 SHALL have ports: d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W; the data load/store request.
REQ-009 SHALL have ports: d_gnt out 1, d_done out 1, d_rdata out DATA_W; the data grant, completion strobe and load data.
REQ-010 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W; the single shared memory port.
REQ-011 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, ACCESS and RESP.
REQ-013 IDLE: when any request is high at a clock edge, the FSM SHALL latch the owner, address, we and wdata, then enter ACCESS with cnt=MEM_LAT-1.
REQ-014 If neither request is high, the FSM SHALL stay in IDLE.
REQ-015 ACCESS: mem_en=1 and mem_addr/mem_we/mem_wdata SHALL be driven from the latched registers, stable for all MEM_LAT cycles.
REQ-016 mem_we SHALL be 0 for fetch accesses.
REQ-017 The owner's gnt SHALL be a one-cycle pulse in the first ACCESS cycle; the requester may drop its req afterwards.
REQ-018 ACCESS with cnt!=0: cnt SHALL decrement; ACCESS with cnt==0: mem_rdata SHALL be captured into the rdata register (reads only), then enter RESP.
REQ-019 RESP: the owner's if_rvalid or d_done SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 Latency: a request sampled at edge N SHALL produce gnt in cycle N+1 and the response in cycle N+1+MEM_LAT.
REQ-021 Back-to-back accesses SHALL be separated by one IDLE cycle.
REQ-022 Both requesters SHALL see the shared rdata register, which is valid only while the matching rvalid/done is high.
REQ-023 The rdata register SHALL hold its value on stores.
REQ-024 Arbitration SHALL use fixed priority with d_req over if_req when both are high in the same IDLE cycle.
REQ-025 A request withdrawn before it is sampled in IDLE SHALL cause no access.
REQ-026 Request changes during ACCESS/RESP SHALL be ignored.
REQ-027 MEM_LAT=1 SHALL give a single ACCESS cycle.
REQ-028 cnt width SHALL be 4 bits.

Reset
REQ-029 rst_n=1 at an edge SHALL force IDLE and cnt=0.
REQ-030 The same reset edge SHALL clear all gnt/rvalid/done/mem_en/mem_we/busy and the rdata/address registers to 0.
REQ-031 Reset during ACCESS SHALL abort the access with no response strobe and mem_en low from the next cycle.
REQ-032 The round-robin pointer SHALL reset to favour data.

Configuration
REQ-033 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that was not the most recent owner.
REQ-034 With MEM_ARB_RR_EN defined, a lone requester SHALL always win.
REQ-035 Without MEM_ARB_RR_EN, arbitration SHALL be fixed data priority with no pointer register.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, RESP=2) and owner constants (OWN_IF=0, OWN_D=1).
REQ-037 The priority/round-robin decision SHALL live in sub-module mem_arb_pick (inputs: if_req, d_req, last owner; output: winner).

Verification
REQ-038 Fetch read test: if_req, if_addr=0x100, mem returns 0x00500093, MEM_LAT=2 -> if_gnt in cycle 1, mem_en high in cycles 1-2, if_rvalid and if_rdata=0x00500093 in cycle 3.
REQ-039 Store test: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_we=1 with stable address/data for 2 cycles, d_done one cycle; if_rdata unchanged.
REQ-040 Simultaneous-request test, macro off: both requests high for 3 accesses -> three data grants, no fetch grant.
REQ-041 Simultaneous-request test, macro on: both requests high for 3 accesses -> grants D, IF, D.
REQ-042 Mid-access reset: rst_n=1 in the second ACCESS cycle -> next cycle IDLE, mem_en=0, busy=0, no rvalid/done.
REQ-043 MEM_LAT=1 load from 0x8 returning 0x42 -> d_gnt in cycle 1, d_done with d_rdata=0x42 in cycle 2.
